// File: rtl/pcie_ring_buffer_pkg.sv
// Shared types and constants for the PCIe PDU ring buffer: flit layout,
// ring index width and the CSR offsets the CPU uses to reach the ring state.
package pcie_ring_buffer_pkg;

    localparam int FLIT_BITS  = 520;
    localparam int PDU_AWIDTH = 12;
    localparam int RING_DEPTH = 1 << PDU_AWIDTH;
    localparam int AF_SLACK_DEFAULT = 64;

    // One ring entry as produced by pdu_gen: 8 bits of sideband plus a 512-bit payload.
    typedef struct packed {
        logic [7:0]   meta;
        logic [511:0] payload;
    } flit_lite_t;

    localparam logic [7:0] CSR_HEAD   = 8'h00;
    localparam logic [7:0] CSR_TAIL   = 8'h04;
    localparam logic [7:0] CSR_OCC    = 8'h08;
    localparam logic [7:0] CSR_STATUS = 8'h0C;

    typedef enum logic [1:0] {
        ERR_BIT_OVERFLOW = 2'd0,
        ERR_BIT_HEAD     = 2'd1
    } err_bit_e;

endpackage

// File: rtl/pcie_ring_buffer_rb_ram.sv
// Simple dual-port ring storage: one write port, one fully pipelined read port
// whose data and valid appear two cycles after the request.
module pcie_ring_buffer_rb_ram #(
    parameter int WIDTH  = 520,
    parameter int AWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] s1_data;
    logic             s1_valid;

    // NOTE: the array and its first read stage carry no reset; clearing a RAM
    // would forbid block-RAM mapping and the contents are never trusted before a write.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Sampling the array in the request cycle gives old-data read-during-write.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            s1_data <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            rd_valid <= s1_valid;
            if (s1_valid) begin
                rd_data <= s1_data;
            end
        end
    end

endmodule

// File: rtl/pcie_ring_buffer.sv
// Host-visible PDU ring: stores producer flits, tracks tail/head/occupancy,
// raises almost_full back-pressure and sticky commit/head errors.
module pcie_ring_buffer
    import pcie_ring_buffer_pkg::*;
#(
    parameter int FLIT_W   = FLIT_BITS,
    parameter int AWIDTH   = PDU_AWIDTH,
    parameter int AF_SLACK = AF_SLACK_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] rb_wr_data,
    input  logic [AWIDTH-1:0] rb_wr_addr,
    input  logic              rb_wr_en,
    input  logic              rb_update_valid,
    input  logic [AWIDTH-1:0] rb_update_size,
    output logic [AWIDTH-1:0] rb_wr_base_addr,
    output logic              rb_almost_full,
    input  logic              head_wr_valid,
    input  logic [AWIDTH-1:0] head_wr_data,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [FLIT_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [AWIDTH:0]   occupancy,
    output logic [AWIDTH-1:0] head,
    output logic              err_overflow,
    output logic              err_head
);

    localparam int DEPTH = 1 << AWIDTH;
    // Two spare bits so occupancy + size never wraps before saturation.
    localparam logic [AWIDTH+1:0] DEPTH_W = (AWIDTH+2)'(DEPTH);
    localparam logic [AWIDTH+1:0] SLACK_W = (AWIDTH+2)'(AF_SLACK);

    logic [AWIDTH-1:0] tail;
    logic [AWIDTH-1:0] consumed;
    logic              head_ok;
    logic              head_bad;
    logic [AWIDTH+1:0] occ_after_consume;
    logic [AWIDTH+1:0] occ_sum;
    logic              overflow;
    logic [AWIDTH:0]   next_occ;
    logic [AWIDTH+1:0] next_free;
    logic              next_af;

    pcie_ring_buffer_rb_ram #(
        .WIDTH  (FLIT_W),
        .AWIDTH (AWIDTH)
    ) u_rb_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (rb_wr_en),
        .wr_addr  (rb_wr_addr),
        .wr_data  (rb_wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

    // NOTE: every signal gets a value before any condition, so no latch is inferred.
    always_comb begin
        consumed          = head_wr_data - head;
        head_ok           = head_wr_valid && ({1'b0, consumed} <= occupancy);
        head_bad          = head_wr_valid && !head_ok;
        occ_after_consume = {1'b0, occupancy} - (head_ok ? {2'b00, consumed} : '0);
        occ_sum           = occ_after_consume
                          + (rb_update_valid ? {2'b00, rb_update_size} : '0);
        overflow          = occ_sum > DEPTH_W;
        next_occ          = overflow ? DEPTH_W[AWIDTH:0] : occ_sum[AWIDTH:0];
        next_free         = DEPTH_W - {1'b0, next_occ};
        next_af           = next_free < SLACK_W;
    end

    // NOTE: state registers use non-blocking assignment so all of them update
    // from the same pre-edge values, matching the flop hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            tail           <= '0;
            head           <= '0;
            occupancy      <= '0;
            rb_almost_full <= 1'b0;
            err_overflow   <= 1'b0;
            err_head       <= 1'b0;
        end else begin
            if (rb_update_valid) begin
                tail <= tail + rb_update_size;
            end
            if (head_ok) begin
                head <= head_wr_data;
            end
            occupancy      <= next_occ;
            rb_almost_full <= next_af;
            if (overflow) begin
                err_overflow <= 1'b1;
            end
            if (head_bad) begin
                err_head <= 1'b1;
            end
        end
    end

    assign rb_wr_base_addr = tail;

endmodule

// File: tb/tb_pcie_ring_buffer.sv
// Directed bench for pcie_ring_buffer: reset, data path, almost_full threshold,
// wrap, simultaneous commit/consume, error flags and reset during a read.
module tb_pcie_ring_buffer;

    localparam int FLIT_W = 520;
    localparam int AWIDTH = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [FLIT_W-1:0] rb_wr_data = '0;
    logic [AWIDTH-1:0] rb_wr_addr = '0;
    logic              rb_wr_en = 1'b0;
    logic              rb_update_valid = 1'b0;
    logic [AWIDTH-1:0] rb_update_size = '0;
    logic [AWIDTH-1:0] rb_wr_base_addr;
    logic              rb_almost_full;
    logic              head_wr_valid = 1'b0;
    logic [AWIDTH-1:0] head_wr_data = '0;
    logic              rd_en = 1'b0;
    logic [AWIDTH-1:0] rd_addr = '0;
    logic [FLIT_W-1:0] rd_data;
    logic              rd_valid;
    logic [AWIDTH:0]   occupancy;
    logic [AWIDTH-1:0] head;
    logic              err_overflow;
    logic              err_head;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pcie_ring_buffer #(
        .FLIT_W   (FLIT_W),
        .AWIDTH   (AWIDTH),
        .AF_SLACK (64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rb_wr_data      (rb_wr_data),
        .rb_wr_addr      (rb_wr_addr),
        .rb_wr_en        (rb_wr_en),
        .rb_update_valid (rb_update_valid),
        .rb_update_size  (rb_update_size),
        .rb_wr_base_addr (rb_wr_base_addr),
        .rb_almost_full  (rb_almost_full),
        .head_wr_valid   (head_wr_valid),
        .head_wr_data    (head_wr_data),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .occupancy       (occupancy),
        .head            (head),
        .err_overflow    (err_overflow),
        .err_head        (err_head)
    );

    function automatic logic [FLIT_W-1:0] mk_flit(input int idx);
        logic [31:0] w;
        w = (32'(idx) * 32'h0101_0101) ^ 32'hDEAD_BEEF;
        return {8'(idx) ^ 8'hC3, {16{w}}};
    endfunction

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rb_wr_en = 1'b0; rb_update_valid = 1'b0; head_wr_valid = 1'b0; rd_en = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic do_update(input logic uv, input logic [AWIDTH-1:0] sz,
                             input logic hv, input logic [AWIDTH-1:0] hd);
        rb_update_valid = uv; rb_update_size = sz;
        head_wr_valid   = hv; head_wr_data   = hd;
        cycle();
        rb_update_valid = 1'b0; head_wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (rb_wr_base_addr !== 12'd0) begin failures++; $display("FAIL reset_tail: got %0d expected 0", rb_wr_base_addr); end
        checks++;
        if (occupancy !== 13'd0) begin failures++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
        checks++;
        if (head !== 12'd0) begin failures++; $display("FAIL reset_head: got %0d expected 0", head); end
        checks++;
        if ({rb_almost_full, rd_valid, err_overflow, err_head} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b expected 0000", {rb_almost_full, rd_valid, err_overflow, err_head});
        end
        checks++;
        if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < 10; i++) begin
            rb_wr_en = 1'b1; rb_wr_addr = 12'(i); rb_wr_data = mk_flit(i);
            cycle();
        end
        rb_wr_en = 1'b0;
        do_update(1'b1, 12'd10, 1'b0, 12'd0);
        checks++;
        if (rb_wr_base_addr !== 12'd10) begin failures++; $display("FAIL commit10_tail: got %0d expected 10", rb_wr_base_addr); end
        checks++;
        if (occupancy !== 13'd10) begin failures++; $display("FAIL commit10_occ: got %0d expected 10", occupancy); end
        checks++;
        if (rb_almost_full !== 1'b0) begin failures++; $display("FAIL commit10_af: got %b expected 0", rb_almost_full); end
        // Back-to-back reads: address s-1 must emerge after the edge that ends iteration s.
        for (int s = 0; s <= 10; s++) begin
            rd_en = (s < 10); rd_addr = 12'(s);
            cycle();
            checks++;
            if (s == 0) begin
                if (rd_valid !== 1'b0) begin failures++; $display("FAIL rd_latency: got valid %b expected 0", rd_valid); end
            end else if (rd_valid !== 1'b1 || rd_data !== mk_flit(s - 1)) begin
                failures++;
                $display("FAIL rd_data_%0d: got v=%b %0h expected v=1 %0h", s - 1, rd_valid, rd_data, mk_flit(s - 1));
            end
        end
        rd_en = 1'b0;
        cycle();
        checks++;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL rd_idle: got valid %b expected 0", rd_valid); end
    endtask

    task automatic test_read_during_write();
        rb_wr_en = 1'b1; rb_wr_addr = 12'd3; rb_wr_data = mk_flit(100);
        rd_en = 1'b1; rd_addr = 12'd3;
        cycle();
        rb_wr_en = 1'b0; rd_en = 1'b0;
        cycle();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== mk_flit(3)) begin
            failures++; $display("FAIL rdw_old: got v=%b %0h expected v=1 %0h", rd_valid, rd_data, mk_flit(3));
        end
        rd_en = 1'b1; rd_addr = 12'd3;
        cycle();
        rd_en = 1'b0;
        cycle();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== mk_flit(100)) begin
            failures++; $display("FAIL rdw_new: got v=%b %0h expected v=1 %0h", rd_valid, rd_data, mk_flit(100));
        end
    endtask

    task automatic test_almost_full();
        do_reset();
        do_update(1'b1, 12'd4000, 1'b0, 12'd0);
        checks++;
        if (rb_almost_full !== 1'b0) begin failures++; $display("FAIL af_4000: got %b expected 0", rb_almost_full); end
        do_update(1'b1, 12'd40, 1'b0, 12'd0);
        checks++;
        if (occupancy !== 13'd4040 || rb_almost_full !== 1'b1) begin
            failures++; $display("FAIL af_4040: got occ=%0d af=%b expected occ=4040 af=1", occupancy, rb_almost_full);
        end
        do_update(1'b0, 12'd0, 1'b1, 12'd100);
        checks++;
        if (occupancy !== 13'd3940 || rb_almost_full !== 1'b0 || head !== 12'd100) begin
            failures++; $display("FAIL af_release: got occ=%0d af=%b head=%0d expected 3940 0 100", occupancy, rb_almost_full, head);
        end
        // Exact threshold: free 64 is not almost full, free 63 is.
        do_reset();
        do_update(1'b1, 12'd4032, 1'b0, 12'd0);
        checks++;
        if (rb_almost_full !== 1'b0) begin failures++; $display("FAIL af_free64: got %b expected 0", rb_almost_full); end
        do_update(1'b1, 12'd1, 1'b0, 12'd0);
        checks++;
        if (rb_almost_full !== 1'b1) begin failures++; $display("FAIL af_free63: got %b expected 1", rb_almost_full); end
    endtask

    task automatic test_wrap();
        do_reset();
        do_update(1'b1, 12'd4090, 1'b0, 12'd0);
        do_update(1'b0, 12'd0, 1'b1, 12'd4090);
        checks++;
        if (head !== 12'd4090 || rb_wr_base_addr !== 12'd4090 || occupancy !== 13'd0) begin
            failures++; $display("FAIL wrap_setup: got head=%0d tail=%0d occ=%0d expected 4090 4090 0", head, rb_wr_base_addr, occupancy);
        end
        do_update(1'b1, 12'd12, 1'b0, 12'd0);
        checks++;
        if (rb_wr_base_addr !== 12'd6 || occupancy !== 13'd12) begin
            failures++; $display("FAIL wrap_commit: got tail=%0d occ=%0d expected 6 12", rb_wr_base_addr, occupancy);
        end
        do_update(1'b0, 12'd0, 1'b1, 12'd6);
        checks++;
        if (head !== 12'd6 || occupancy !== 13'd0) begin
            failures++; $display("FAIL wrap_consume: got head=%0d occ=%0d expected 6 0", head, occupancy);
        end
        do_update(1'b0, 12'd0, 1'b1, 12'd6);
        checks++;
        if (err_head !== 1'b0 || head !== 12'd6) begin
            failures++; $display("FAIL head_same: got err=%b head=%0d expected 0 6", err_head, head);
        end
        do_update(1'b1, 12'd0, 1'b0, 12'd0);
        checks++;
        if (rb_wr_base_addr !== 12'd6 || occupancy !== 13'd0) begin
            failures++; $display("FAIL size0_noop: got tail=%0d occ=%0d expected 6 0", rb_wr_base_addr, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        do_update(1'b1, 12'd20, 1'b0, 12'd0);
        do_update(1'b1, 12'd8, 1'b1, 12'd11);
        checks++;
        if (occupancy !== 13'd23 || rb_wr_base_addr !== 12'd34 || head !== 12'd11) begin
            failures++; $display("FAIL simul: got occ=%0d tail=%0d head=%0d expected 23 34 11", occupancy, rb_wr_base_addr, head);
        end
    endtask

    task automatic test_errors();
        do_reset();
        do_update(1'b1, 12'd5, 1'b0, 12'd0);
        do_update(1'b0, 12'd0, 1'b1, 12'd6);
        checks++;
        if (head !== 12'd0 || occupancy !== 13'd5 || err_head !== 1'b1) begin
            failures++; $display("FAIL err_head: got head=%0d occ=%0d err=%b expected 0 5 1", head, occupancy, err_head);
        end
        do_update(1'b1, 12'd4088, 1'b0, 12'd0);
        checks++;
        if (err_overflow !== 1'b0) begin failures++; $display("FAIL ovf_early: got %b expected 0", err_overflow); end
        do_update(1'b1, 12'd10, 1'b0, 12'd0);
        checks++;
        if (occupancy !== 13'd4096 || err_overflow !== 1'b1 || rb_wr_base_addr !== 12'd7) begin
            failures++; $display("FAIL ovf: got occ=%0d err=%b tail=%0d expected 4096 1 7", occupancy, err_overflow, rb_wr_base_addr);
        end
        checks++;
        if (err_head !== 1'b1 || rb_almost_full !== 1'b1) begin
            failures++; $display("FAIL sticky: got err_head=%b af=%b expected 1 1", err_head, rb_almost_full);
        end
    endtask

    task automatic test_reset_mid_read();
        rd_en = 1'b1; rd_addr = 12'd0;
        cycle();
        rd_en = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_drop_%0d: got valid %b expected 0", i, rd_valid); end
            cycle();
        end
        checks++;
        if (rb_wr_base_addr !== 12'd0 || head !== 12'd0 || occupancy !== 13'd0) begin
            failures++; $display("FAIL rst_ptrs: got tail=%0d head=%0d occ=%0d expected 0 0 0", rb_wr_base_addr, head, occupancy);
        end
        checks++;
        if ({err_overflow, err_head, rb_almost_full} !== 3'b000) begin
            failures++; $display("FAIL rst_errs: got %b expected 000", {err_overflow, err_head, rb_almost_full});
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_write_read();
        test_read_during_write();
        test_almost_full();
        test_wrap();
        test_back_to_back();
        test_errors();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pcie_ring_buffer.md
Name: pcie_ring_buffer

Overview:
Host-visible PDU ring buffer that consumes the PCIe ring-buffer write stream from pdu_gen (flit writes plus per-PDU commit updates) and exposes its space/base state back to the producer. It tracks the producer tail, the CPU-owned head and the committed occupancy, and drives almost_full back-pressure. A registered read port feeds the PCIe DMA read engine and CPU CSR path.

Parameters:
FLIT_W, 520, width of one ring entry (flit_lite_t bits)
AWIDTH, 12, ring index width; DEPTH = 2**AWIDTH entries
AF_SLACK, 64, almost_full asserts when free entries < AF_SLACK

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rb_wr_data  in  FLIT_W  flit to store
rb_wr_addr  in  AWIDTH  absolute ring index for rb_wr_data
rb_wr_en  in  1  write strobe
rb_update_valid  in  1  commit strobe; advances tail
rb_update_size  in  AWIDTH  flits committed by this update
rb_wr_base_addr  out  AWIDTH  current tail (next free index)
rb_almost_full  out  1  back-pressure to producer
head_wr_valid  in  1  CPU head-pointer write
head_wr_data  in  AWIDTH  new head index
rd_en  in  1  read request
rd_addr  in  AWIDTH  read index
rd_data  out  FLIT_W  read result
rd_valid  out  1  rd_data valid
occupancy  out  AWIDTH+1  committed, unconsumed flits
head  out  AWIDTH  current head
err_overflow  out  1  sticky: commit exceeded free space
err_head  out  1  sticky: illegal head write

Behaviour:
- Reset: tail=0, head=0, occupancy=0, rb_almost_full=0, rd_valid=0, rd_data=0, err_*=0. Memory contents not cleared. Reset mid-read drops in-flight reads (no rd_valid after reset).
- Storage: simple dual-port RAM, DEPTH x FLIT_W. Write on rb_wr_en at rb_wr_addr, 1 cycle. No address checking on writes; the producer owns base+offset mod DEPTH.
- Read: rd_en at cycle N -> rd_data/rd_valid at N+2 (registered address, registered output). Fully pipelined, one read per cycle. Same-address write and read in the same cycle returns old data.
- Commit: rb_update_valid -> tail <= (tail + rb_update_size) mod DEPTH (natural AWIDTH wrap). occupancy += size.
- rb_update_size = 0 is a no-op.
- If size > free (free = DEPTH - occupancy): tail still advances, occupancy saturates at DEPTH, err_overflow sets.
- Consume: head_wr_valid -> consumed = (head_wr_data - head) mod DEPTH.
  - If consumed <= occupancy: head <= head_wr_data and occupancy -= consumed.
  - Otherwise: write ignored and err_head sets.
  - Writing head equal to the current head consumes 0 flits.
- Simultaneous commit and consume in one cycle: the consume check uses pre-update occupancy. Next occupancy = occ - consumed + size, with saturation applied after.
- Full vs empty: head == tail is ambiguous; occupancy (AWIDTH+1 bits) is authoritative. DEPTH means full, 0 means empty.
- rb_wr_base_addr: equals the tail register (updated the cycle after commit).
- rb_almost_full: registered, = (DEPTH - next_occupancy) < AF_SLACK. Valid the cycle after any occupancy change.
- Sticky errors clear only on rst.

Decomposition:
- Shared package (struct_s): flit_lite_t, PDU_AWIDTH, ring CSR offsets.
- One sub-module: rb_ram (simple dual-port RAM, 2-cycle registered read, parameterised width/depth).
- Pointer/occupancy logic is kept in the top level.

Test Plan:
- Reset, then write flits idx 0..9 and commit size 10 -> base_addr=10, occupancy=10, almost_full=0; rd_addr 0..9 return the written data 2 cycles after each rd_en.
- Commit 4040 total (DEPTH 4096, AF_SLACK 64) -> free=56, almost_full=1 the next cycle; head write to 100 -> occupancy 3940, almost_full=0.
- Wrap: head=tail=4090, commit 12 -> tail=6, occupancy=12; head write 6 -> consumed 12, occupancy 0.
- Same-cycle commit 8 and head advance 5 with occupancy 20 -> occupancy 23, tail+8, head+5.
- Illegal: occupancy 5, head write to head+6 -> head unchanged, err_head=1. Commit 10 with free 3 -> occupancy 4096, err_overflow=1.
- Reset asserted one cycle after rd_en -> no rd_valid; all pointers 0; sticky errors cleared.
